// File: rtl/phase_timer.sv
// phase_timer: per-phase timeout generator and latched side-road request for the traffic-light controller
module phase_timer #(
    parameter int TICK_DIV      = 50_000_000,
    parameter int T_MAIN_GREEN  = 30,
    parameter int T_SIDE_YELLOW = 3,
    parameter int T_SIDE_GREEN  = 15,
    parameter int T_MAIN_YELLOW = 3,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       c_state,
    input  logic [1:0]       n_state,
    input  logic             side_car_raw,
    output logic             time_out,
    output logic             side_car_detected,
    output logic [CNT_W-1:0] sec_remaining,
    output logic             tick
);
    localparam int PW = $clog2(TICK_DIV);
    logic [PW-1:0]    pre;
    logic [CNT_W-1:0] dur;
    logic             chg, s1, s2;
    always_comb begin
        chg  = n_state != c_state;
        tick = pre == PW'(TICK_DIV - 1);
        dur  = n_state == 2'b00 ? CNT_W'(T_MAIN_GREEN)  :
               n_state == 2'b01 ? CNT_W'(T_SIDE_YELLOW) :
               n_state == 2'b11 ? CNT_W'(T_SIDE_GREEN)  : CNT_W'(T_MAIN_YELLOW);
    end
    // A phase change restarts the whole second from zero and wins over any tick in the same cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            pre           <= '0;
            sec_remaining <= CNT_W'(T_MAIN_GREEN);
            time_out      <= 1'b0;
        end else if (chg) begin
            pre           <= '0;
            sec_remaining <= dur;
            time_out      <= 1'b0;
        end else begin
            pre <= tick ? '0 : pre + 1'b1;
            if (tick && sec_remaining != '0) begin
                sec_remaining <= sec_remaining - 1'b1;
                if (sec_remaining == CNT_W'(1)) time_out <= 1'b1;
            end
        end
    end
    // Request is dropped for the whole side-green phase, so a car seen then must still be present afterwards
    always_ff @(posedge clk) begin
        if (rst) begin
            s1                <= 1'b0;
            s2                <= 1'b0;
            side_car_detected <= 1'b0;
        end else begin
            s1                <= side_car_raw;
            s2                <= s1;
            side_car_detected <= c_state == 2'b11 ? 1'b0 : (s2 | side_car_detected);
        end
    end
endmodule
